dll_lock_detect: RTL

- Frequency-lock monitor that sits directly downstream of the digital locked loop.
- Runs on the DLL output clock (clockp[0]) and counts DLL cycles per period of the reference oscillator `osc`. It compares that count against the programmed feedback ratio `div`.
- Asserts `locked` after a configurable run of in-tolerance periods, and flags loss of lock for use by the clock/reset sequencer.

---
 rtl/dll_lock_detect.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/dll_lock_detect.sv
// Frequency-lock monitor: counts DLL clock cycles per reference-oscillator period and tracks lock.
// Optional lock-loss hysteresis (two consecutive bad windows to drop lock): define DLL_LOCK_HYST_EN.
module dll_lock_detect #(
    parameter int DIV_W    = 5,
    parameter int CNT_W    = 8,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [DIV_W-1:0] div,
    output logic             locked,
    output logic             lost,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid
);

    localparam logic [CNT_W-1:0] PCNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PCNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] PCNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PCNT_ZERO = {CNT_W{1'b0}};
    localparam logic [7:0]       GCNT_MAX  = 8'hFF;
    localparam logic [7:0]       LOCK_TGT  = 8'(LOCK_CNT);
    localparam logic [CNT_W:0]   TOL_MAG   = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [7:0]       gcnt_q, gcnt_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
`ifdef DLL_LOCK_HYST_EN
    logic             miss_q, miss_d;
    logic             stall_q, stall_d;
`endif

    logic             rise_s;
    logic             good_s;
    logic             bad_win_s;
    logic [CNT_W-1:0] pcnt_inc_s;
    logic [7:0]       gcnt_inc_s;

    // A window is good when the measured count is within TOL of div; saturated counts and div=0 never are.
    function automatic logic window_good(input logic [CNT_W-1:0] m, input logic [DIV_W-1:0] d);
        logic signed [CNT_W:0] diff;
        logic [CNT_W:0]        mag;
        diff = $signed({1'b0, m}) - $signed({{(CNT_W+1-DIV_W){1'b0}}, d});
        if (diff[CNT_W]) begin
            mag = $unsigned(-diff);
        end else begin
            mag = $unsigned(diff);
        end
        return (d != {DIV_W{1'b0}}) && (m != PCNT_MAX) && (mag <= TOL_MAG);
    endfunction

    assign rise_s     = sync_q[1] & ~sync_q[2];
    assign good_s     = window_good(pcnt_q, div);
    assign pcnt_inc_s = (pcnt_q == PCNT_MAX) ? PCNT_MAX : (pcnt_q + PCNT_ONE);
    assign gcnt_inc_s = (gcnt_q == GCNT_MAX) ? GCNT_MAX : (gcnt_q + 8'd1);

    // Next-state, counter and output logic.
    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[1:0], osc};
        pcnt_d       = pcnt_q;
        gcnt_d       = gcnt_q;
        locked_d     = locked_q;
        lost_d       = 1'b0;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        bad_win_s    = 1'b0;
`ifdef DLL_LOCK_HYST_EN
        miss_d       = miss_q;
        stall_d      = stall_q;
`endif
        if (!enable) begin
            // Intentional disable: no lost pulse, period keeps its last value.
            state_d  = ST_IDLE;
            pcnt_d   = PCNT_ZERO;
            gcnt_d   = 8'd0;
            locked_d = 1'b0;
`ifdef DLL_LOCK_HYST_EN
            miss_d   = 1'b0;
            stall_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    pcnt_d  = PCNT_ZERO;
                end
                ST_ACQ: begin
                    // The first window is partial; restart counting without reporting it.
                    if (rise_s) begin
                        pcnt_d  = PCNT_ONE;
                        state_d = ST_TRACK;
                    end else begin
                        pcnt_d = pcnt_inc_s;
                    end
                end
                ST_TRACK: begin
                    if (rise_s) begin
                        pcnt_d       = PCNT_ONE;
                        period_d     = pcnt_q;
                        meas_valid_d = 1'b1;
                        if (good_s) begin
                            gcnt_d = gcnt_inc_s;
                            if (gcnt_inc_s >= LOCK_TGT) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                state_d = ST_TRACK;
                            end
                        end else begin
                            gcnt_d = 8'd0;
                        end
                    end else begin
                        pcnt_d = pcnt_inc_s;
                    end
                end
                ST_LOCKED: begin
                    if (rise_s) begin
                        pcnt_d       = PCNT_ONE;
                        period_d     = pcnt_q;
                        meas_valid_d = 1'b1;
`ifdef DLL_LOCK_HYST_EN
                        // A window already judged as a stall is not judged a second time.
                        stall_d = 1'b0;
                        if (good_s) begin
                            miss_d = 1'b0;
                        end else begin
                            bad_win_s = ~stall_q;
                        end
`else
                        bad_win_s = ~good_s;
`endif
                    end else begin
                        pcnt_d = pcnt_inc_s;
                        // Counter about to saturate with no osc edge: the window is bad right now.
                        if (pcnt_q == PCNT_PRE) begin
                            bad_win_s = 1'b1;
`ifdef DLL_LOCK_HYST_EN
                            stall_d   = 1'b1;
`endif
                        end else begin
                            bad_win_s = 1'b0;
                        end
                    end
                    if (bad_win_s) begin
`ifdef DLL_LOCK_HYST_EN
                        if (miss_q) begin
                            state_d  = ST_TRACK;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                            gcnt_d   = 8'd0;
                            miss_d   = 1'b0;
                            stall_d  = 1'b0;
                        end else begin
                            miss_d = 1'b1;
                        end
`else
                        state_d  = ST_TRACK;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                        gcnt_d   = 8'd0;
`endif
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    pcnt_d   = PCNT_ZERO;
                    gcnt_d   = 8'd0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            sync_q       <= 3'b000;
            pcnt_q       <= PCNT_ZERO;
            gcnt_q       <= 8'd0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            period_q     <= PCNT_ZERO;
            meas_valid_q <= 1'b0;
`ifdef DLL_LOCK_HYST_EN
            miss_q       <= 1'b0;
            stall_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            pcnt_q       <= pcnt_d;
            gcnt_q       <= gcnt_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
`ifdef DLL_LOCK_HYST_EN
            miss_q       <= miss_d;
            stall_q      <= stall_d;
`endif
        end
    end

    assign locked     = locked_q;
    assign lost       = lost_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;

endmodule
